score_drawer: RTL and testbench
===============================

# score_drawer

Sequential renderer that turns a binary score into on-screen digits for the 160x120 VGA frame buffer. It saturates the score at 999 and converts it to BCD. It then sweeps every pixel of each 16x32 digit glyph, drives the glyph-ROM lookup (digit id, column, row), realigns the returned colour with the pixel coordinates, and emits one VGA adapter write per pixel. It sits between the game score counter (upstream) and the glyph reader plus VGA adapter (downstream).

## Interface
Parameters:
- DIGITS, 3: number of decimal digits drawn, most significant digit leftmost.
- X0, 8'd100: x of the leftmost glyph's top-left pixel.
- Y0, 7'd4: y of the glyph top row.
- GAP, 2: blank columns between glyphs; these columns are not drawn.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request to draw; sampled only in IDLE.
- score  in  10  binary score; captured on the accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last plot.
- glyph_id  out  4  digit value 0–9 presented to the glyph reader.
- glyph_i  out  5  glyph column 0–15; bit 4 is always 0.
- glyph_j  out  7  glyph row 0–31.
- glyph_colour  in  3  reader output, valid one cycle after the address.
- x  out  8  VGA x.
- y  out  7  VGA y.
- colour  out  3  VGA colour.
- plot  out  1  VGA write enable.

## Operation
- States:
  - IDLE: busy=0. A start pulse captures min(score, 999) and moves to CONVERT.
  - CONVERT: 10-cycle shift-add-3 binary-to-BCD conversion, one input bit per cycle. Moves to SWEEP.
  - SWEEP: walks pixel index k = 0..N-1, where N = DIGITS*512. Order is digit d (MSD first), then row j 0–31, then column i 0–15; i is innermost. Moves to DRAIN after k = N-1.
  - DRAIN: one cycle that flushes the last pixel. Moves to DONE.
  - DONE: pulses done for one cycle, then returns to IDLE.
- Leading zeros are drawn as the glyph "0" (no blanking).
- Pixel coordinates are x = X0 + d*(16+GAP) + i and y = Y0 + j. Arithmetic is 8-bit and 7-bit unsigned. The defaults fit on screen and no wrap check is made; choosing parameters that fit is the integrator's job.
- glyph_colour is forwarded unmodified: every pixel is plotted, so black erases a previously drawn digit.
- x and y travel through a one-stage pipeline register so that they arrive together with glyph_colour.
- start while busy is ignored; score changes while busy are ignored.
- reset at any time returns to IDLE on the next edge and clears pending plots. The partly drawn image is left as is.

## Timing
- All outputs are registered except glyph_id, glyph_i and glyph_j, which decode combinationally from the counters.
- Reset values: busy=0, done=0, plot=0, x=0, y=0, colour=0, glyph_id=0, glyph_i=0, glyph_j=0, state IDLE.
- start is accepted at edge 0, and busy is high after edge 0.
- CONVERT occupies edges 1–10.
- The address for pixel k is driven after edge 10+k and sampled by the ROM at edge 11+k.
- plot=1 with x, y and colour for pixel k holds after edge 12+k.
- The last plot holds after edge 11+N. done=1 and busy=0 hold after edge 12+N; for DIGITS=3 that is edge 1548.
- plot is continuous during SWEEP with no gaps. A start pulse arriving together with done being high is ignored; a new request is accepted in the next cycle.

## Structure
- Shared package score_pkg holds:
  - GLYPH_W=16 and GLYPH_H=32;
  - the VGA width constants (8, 7, 3);
  - SCORE_MAX=999;
  - the state enum {IDLE, CONVERT, SWEEP, DRAIN, DONE}.
- Sub-module bin2bcd_seq does the 10-cycle double-dabble. Interface: clock, reset, load, bin[9:0], bcd[11:0], valid.
- The counters, coordinate arithmetic and pipeline register live in score_drawer.

## Test plan
The bench uses a 1-cycle-latency ROM model returning colour = (id + i + j) mod 8 to check alignment.
- score=427: glyph_id sequence 4, 2, 7; first plot x=100, y=4, colour=4. The first pixel of digit 1 is at x=118. done at edge 1548 with 1536 plots.
- score=0: all glyph_id=0; last plot at x=100+36+15=151, y=35, colour=(0+15+31) mod 8=6.
- score=1023: saturates to 9, 9, 9; colour on every plot matches the model for its (id, i, j).
- start pulsed at edge 500 while busy: ignored. Plot count stays 1536 and there is exactly one done pulse.
- reset asserted at edge 800: after edge 801 plot=0 and busy=0 (edge-801 sample is plot=0, busy=0). A subsequent start with score=5 draws 0, 0, 5 correctly.
- start together with score=999 in the cycle done is high: ignored. start one cycle later is accepted, with busy rising after that edge.

Source files
------------

// File: rtl/score_pkg.sv
// Shared constants, state encoding and pixel payload for the score renderer.
package score_pkg;

    localparam int unsigned GLYPH_W    = 16;
    localparam int unsigned GLYPH_H    = 32;
    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;
    localparam int unsigned COLOUR_W   = 3;
    localparam int unsigned SCORE_W    = 10;
    localparam int unsigned BCD_DIGITS = 3;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned SCORE_MAX  = 999;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pix_t;

    // Clamp a raw score to the largest value three digits can show.
    function automatic logic [SCORE_W-1:0] saturate(input logic [SCORE_W-1:0] s);
        return (s > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one binary bit shifted in per cycle, valid after SCORE_W shifts.
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [SCORE_W-1:0] bin,
    output logic [BCD_W-1:0]   bcd,
    output logic               valid
);

    logic [SCORE_W-1:0] sh;
    logic [3:0]         cnt;
    logic               run;
    logic [BCD_W-1:0]   adj;

    // Add 3 to every digit of 5 or more before the shift.
    always_comb begin
        adj = bcd;
        for (int n = 0; n < int'(BCD_DIGITS); n++) begin
            if (adj[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sh    <= '0;
            bcd   <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            sh    <= bin;
            bcd   <= '0;
            cnt   <= '0;
            run   <= 1'b1;
            valid <= 1'b0;
        end else if (run) begin
            bcd <= {adj[BCD_W-2:0], sh[SCORE_W-1]};
            sh  <= {sh[SCORE_W-2:0], 1'b0};
            cnt <= cnt + 4'd1;
            if (cnt == 4'(SCORE_W - 1)) begin
                run   <= 1'b0;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_drawer.sv
// Renders a saturated score as DIGITS glyphs, one VGA plot per glyph pixel.
module score_drawer
    import score_pkg::*;
#(
    parameter int unsigned    DIGITS = 3,
    parameter logic [X_W-1:0] X0     = 8'd100,
    parameter logic [Y_W-1:0] Y0     = 7'd4,
    parameter int unsigned    GAP    = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [SCORE_W-1:0]  score,
    output logic                busy,
    output logic                done,
    output logic [3:0]          glyph_id,
    output logic [4:0]          glyph_i,
    output logic [6:0]          glyph_j,
    input  logic [COLOUR_W-1:0] glyph_colour,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    localparam int unsigned DW          = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned IW          = $clog2(GLYPH_W);
    localparam int unsigned JW          = $clog2(GLYPH_H);
    localparam int unsigned PITCH       = GLYPH_W + GAP;
    localparam int unsigned CONV_CYCLES = SCORE_W;

    state_t           state, state_nxt;
    logic             load_c;
    logic             busy_d, done_d;
    logic             last_c;
    logic [3:0]       conv_cnt;
    logic [IW-1:0]    i_cnt;
    logic [JW-1:0]    j_cnt;
    logic [DW-1:0]    d_cnt;
    logic [BCD_W-1:0] bcd;
    logic             bcd_valid;
    pix_t             pix_c, p1_pix;
    logic             p1_valid;

    bin2bcd_seq u_bcd (
        .clock (clock),
        .reset (reset),
        .load  (load_c),
        .bin   (saturate(score)),
        .bcd   (bcd),
        .valid (bcd_valid)
    );

    assign last_c = (state == SWEEP)
                 && (i_cnt == IW'(GLYPH_W - 1))
                 && (j_cnt == JW'(GLYPH_H - 1))
                 && (d_cnt == DW'(DIGITS - 1));

    // Next state; a start coinciding with the done pulse is deliberately dropped.
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !done) begin
                    load_c    = 1'b1;
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                if (conv_cnt == 4'(CONV_CYCLES - 1)) begin
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                if (last_c) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_d = (state_nxt != IDLE);
        done_d = (state == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Conversion timer and pixel walk: column innermost, then row, then digit.
    always_ff @(posedge clock) begin
        if (reset) begin
            conv_cnt <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            d_cnt    <= '0;
        end else begin
            case (state)
                CONVERT: conv_cnt <= conv_cnt + 4'd1;
                SWEEP: begin
                    i_cnt <= i_cnt + IW'(1);
                    if (i_cnt == IW'(GLYPH_W - 1)) begin
                        j_cnt <= j_cnt + JW'(1);
                        if (j_cnt == JW'(GLYPH_H - 1)) begin
                            d_cnt <= last_c ? '0 : d_cnt + DW'(1);
                        end
                    end
                end
                default: begin
                    conv_cnt <= '0;
                    i_cnt    <= '0;
                    j_cnt    <= '0;
                    d_cnt    <= '0;
                end
            endcase
        end
    end

    // Digit d counts from the left, so it reads BCD nibble DIGITS-1-d.
    always_comb begin
        glyph_id = '0;
        for (int n = 0; n < int'(BCD_DIGITS); n++) begin
            if (bcd_valid && (int'(d_cnt) + n == int'(DIGITS) - 1)) begin
                glyph_id = bcd[n*4 +: 4];
            end
        end
    end

    assign glyph_i = 5'(i_cnt);
    assign glyph_j = 7'(j_cnt);

    always_comb begin
        pix_c   = '0;
        pix_c.x = X0 + X_W'(int'(d_cnt) * int'(PITCH)) + X_W'(i_cnt);
        pix_c.y = Y0 + Y_W'(j_cnt);
    end

    // Coordinates wait one stage so they meet the ROM colour for the same pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            p1_valid <= 1'b0;
            p1_pix   <= '0;
            plot     <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
        end else begin
            p1_valid <= (state == SWEEP);
            p1_pix   <= pix_c;
            plot     <= p1_valid;
            x        <= p1_pix.x;
            y        <= p1_pix.y;
            colour   <= glyph_colour;
        end
    end

endmodule

// File: tb/tb_score_drawer.sv
// Bench for score_drawer: 1-cycle glyph ROM model plus a queue of expected plots.
module tb_score_drawer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] score;
    logic       busy, done;
    logic [3:0] glyph_id;
    logic [4:0] glyph_i;
    logic [6:0] glyph_j;
    logic [2:0] glyph_colour;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          plot_count = 0;
    int          done_count = 0;
    logic [17:0] exp_q[$];
    logic [17:0] exp_pix;

    score_drawer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .score        (score),
        .busy         (busy),
        .done         (done),
        .glyph_id     (glyph_id),
        .glyph_i      (glyph_i),
        .glyph_j      (glyph_j),
        .glyph_colour (glyph_colour),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        glyph_colour <= 3'((int'(glyph_id) + int'(glyph_i) + int'(glyph_j)) % 8);

    always @(negedge clock) begin
        if (!reset && plot) begin
            plot_count++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pixel_extra: plot x=%0d y=%0d colour=%0d with nothing expected", x, y, colour);
            end else begin
                exp_pix = exp_q.pop_front();
                if ({x, y, colour} !== exp_pix) begin
                    n_fail++;
                    $display("FAIL pixel: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                             x, y, colour, exp_pix[17:10], exp_pix[9:3], exp_pix[2:0]);
                end
            end
        end
        if (!reset && done) done_count++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_frame(input int s);
        int sat;
        int dig[3];
        sat    = (s > 999) ? 999 : s;
        dig[0] = sat / 100;
        dig[1] = (sat / 10) % 10;
        dig[2] = sat % 10;
        for (int d = 0; d < 3; d++)
            for (int j = 0; j < 32; j++)
                for (int i = 0; i < 16; i++)
                    exp_q.push_back({8'(100 + d * 18 + i), 7'(4 + j), 3'((dig[d] + i + j) % 8)});
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; score = '0;
        tick(); tick();
        n_tests++;
        if ({busy, done, plot} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000", {busy, done, plot});
        end
        n_tests++;
        if ({x, y, colour} !== 18'd0) begin
            n_fail++; $display("FAIL reset_pix: got x=%0d y=%0d c=%0d want 0", x, y, colour);
        end
        n_tests++;
        if ({glyph_id, glyph_i, glyph_j} !== 16'd0) begin
            n_fail++; $display("FAIL reset_glyph: got id=%0d i=%0d j=%0d want 0", glyph_id, glyph_i, glyph_j);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_score_427();
        plot_count = 0; done_count = 0;
        score = 10'd427; start = 1'b1; push_frame(427);
        tick(); start = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL 427_busy_rise: got %b want 1", busy); end
        for (int e = 1; e <= 1549; e++) begin
            tick();
            if (e == 10) begin
                n_tests++;
                if ({glyph_id, glyph_i, glyph_j} !== {4'd4, 5'd0, 7'd0}) begin
                    n_fail++; $display("FAIL 427_addr0: got id=%0d i=%0d j=%0d want 4 0 0", glyph_id, glyph_i, glyph_j);
                end
            end
            if (e == 522) begin
                n_tests++;
                if (glyph_id !== 4'd2) begin n_fail++; $display("FAIL 427_id1: got %0d want 2", glyph_id); end
            end
            if (e == 1034) begin
                n_tests++;
                if (glyph_id !== 4'd7) begin n_fail++; $display("FAIL 427_id2: got %0d want 7", glyph_id); end
            end
            if (e == 11) begin
                n_tests++;
                if (plot !== 1'b0) begin n_fail++; $display("FAIL 427_no_early_plot: got %b want 0", plot); end
            end
            if (e == 12) begin
                n_tests++;
                if ({plot, x, y, colour} !== {1'b1, 8'd100, 7'd4, 3'd4}) begin
                    n_fail++; $display("FAIL 427_first_plot: got p=%b x=%0d y=%0d c=%0d want 1 100 4 4", plot, x, y, colour);
                end
            end
            if (e == 524) begin
                n_tests++;
                if ({plot, x} !== {1'b1, 8'd118}) begin
                    n_fail++; $display("FAIL 427_digit1_x: got p=%b x=%0d want 1 118", plot, x);
                end
            end
            if (e == 1547) begin
                n_tests++;
                if ({done, busy} !== 2'b01) begin n_fail++; $display("FAIL 427_pre_done: got %b want 01", {done, busy}); end
            end
            if (e == 1548) begin
                n_tests++;
                if ({done, busy, plot} !== 3'b100) begin n_fail++; $display("FAIL 427_done: got %b want 100", {done, busy, plot}); end
                n_tests++;
                if (plot_count !== 1536) begin n_fail++; $display("FAIL 427_plot_count: got %0d want 1536", plot_count); end
            end
            if (e == 1549) begin
                n_tests++;
                if ({done, done_count} !== {1'b0, 32'd1}) begin
                    n_fail++; $display("FAIL 427_done_pulse: got done=%b count=%0d want 0 1", done, done_count);
                end
                n_tests++;
                if (exp_q.size() !== 0) begin n_fail++; $display("FAIL 427_queue: got %0d left want 0", exp_q.size()); end
            end
        end
    endtask

    task automatic test_zero();
        plot_count = 0; done_count = 0;
        score = 10'd0; start = 1'b1; push_frame(0);
        tick(); start = 1'b0;
        for (int e = 1; e <= 1548; e++) begin
            tick();
            if (e == 10 || e == 522 || e == 1034) begin
                n_tests++;
                if (glyph_id !== 4'd0) begin n_fail++; $display("FAIL zero_id at edge %0d: got %0d want 0", e, glyph_id); end
            end
            if (e == 1547) begin
                n_tests++;
                if ({plot, x, y, colour} !== {1'b1, 8'd151, 7'd35, 3'd6}) begin
                    n_fail++; $display("FAIL zero_last_plot: got p=%b x=%0d y=%0d c=%0d want 1 151 35 6", plot, x, y, colour);
                end
            end
            if (e == 1548) begin
                n_tests++;
                if ({done, plot_count} !== {1'b1, 32'd1536}) begin
                    n_fail++; $display("FAIL zero_done: got done=%b plots=%0d want 1 1536", done, plot_count);
                end
            end
        end
        tick();
    endtask

    task automatic test_saturate_busy_start();
        plot_count = 0; done_count = 0;
        score = 10'd1023; start = 1'b1; push_frame(1023);
        tick(); start = 1'b0;
        for (int e = 1; e <= 1549; e++) begin
            tick();
            if (e == 499) begin score = 10'd5; start = 1'b1; end
            if (e == 500) start = 1'b0;
            if (e == 10 || e == 1034) begin
                n_tests++;
                if (glyph_id !== 4'd9) begin n_fail++; $display("FAIL sat_id at edge %0d: got %0d want 9", e, glyph_id); end
            end
            if (e == 1548) begin
                n_tests++;
                if ({done, busy, plot_count} !== {1'b1, 1'b0, 32'd1536}) begin
                    n_fail++; $display("FAIL sat_done: got done=%b busy=%b plots=%0d want 1 0 1536", done, busy, plot_count);
                end
            end
            if (e == 1549) begin
                n_tests++;
                if ({busy, done_count} !== {1'b0, 32'd1}) begin
                    n_fail++; $display("FAIL sat_single_done: got busy=%b dones=%0d want 0 1", busy, done_count);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        plot_count = 0; done_count = 0;
        score = 10'd427; start = 1'b1; push_frame(427);
        tick(); start = 1'b0;
        for (int e = 1; e <= 799; e++) tick();
        reset = 1'b1;
        tick(); tick();
        n_tests++;
        if ({plot, busy, done} !== 3'b000) begin
            n_fail++; $display("FAIL midreset: got plot/busy/done=%b want 000", {plot, busy, done});
        end
        reset = 1'b0;
        exp_q.delete();
        plot_count = 0; done_count = 0;
        score = 10'd5; start = 1'b1; push_frame(5);
        tick(); start = 1'b0;
        for (int e = 1; e <= 1549; e++) begin
            tick();
            if (e == 10 || e == 522) begin
                n_tests++;
                if (glyph_id !== 4'd0) begin n_fail++; $display("FAIL post_reset_id at edge %0d: got %0d want 0", e, glyph_id); end
            end
            if (e == 1034) begin
                n_tests++;
                if (glyph_id !== 4'd5) begin n_fail++; $display("FAIL post_reset_id2: got %0d want 5", glyph_id); end
            end
            if (e == 1548) begin
                n_tests++;
                if ({done, plot_count} !== {1'b1, 32'd1536}) begin
                    n_fail++; $display("FAIL post_reset_done: got done=%b plots=%0d want 1 1536", done, plot_count);
                end
            end
            if (e == 1549) begin
                n_tests++;
                if (exp_q.size() !== 0) begin n_fail++; $display("FAIL post_reset_queue: got %0d left want 0", exp_q.size()); end
            end
        end
    endtask

    task automatic test_back_to_back();
        plot_count = 0; done_count = 0;
        score = 10'd58; start = 1'b1; push_frame(58);
        tick(); start = 1'b0;
        for (int e = 1; e <= 1548; e++) tick();
        n_tests++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b want 1", done); end
        score = 10'd999; start = 1'b1;
        tick();
        n_tests++;
        if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL b2b_start_on_done: got busy/done=%b want 00", {busy, done}); end
        push_frame(999);
        tick(); start = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        for (int e = 1; e <= 1549; e++) begin
            tick();
            if (e == 10) begin
                n_tests++;
                if (glyph_id !== 4'd9) begin n_fail++; $display("FAIL b2b_id: got %0d want 9", glyph_id); end
            end
            if (e == 1548) begin
                n_tests++;
                if ({done, plot_count} !== {1'b1, 32'd3072}) begin
                    n_fail++; $display("FAIL b2b_done: got done=%b plots=%0d want 1 3072", done, plot_count);
                end
            end
            if (e == 1549) begin
                n_tests++;
                if ({done_count, exp_q.size()} !== {32'd2, 32'd0}) begin
                    n_fail++; $display("FAIL b2b_totals: got dones=%0d left=%0d want 2 0", done_count, exp_q.size());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_score_427();
        test_zero();
        test_saturate_busy_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
